// File: rtl/stm1_pkg.sv
// Shared definitions for the STM-1 TX frame scheduler slice.
//  - Frame geometry (bits per frame/row, rows, columns, overhead extents).
//  - Counter widths for pos/row/col/bitn.
//  - Scheduler FSM state type {IDLE, RUN}.
package stm1_pkg;

    localparam int STM1_FRAME_BITS = 19440;
    localparam int STM1_ROW_BITS   = 2160;
    localparam int STM1_COLS       = 270;
    localparam int STM1_ROWS       = 9;
    localparam int STM1_SOH_COLS   = 9;
    localparam int STM1_RSOH_ROWS  = 3;
    localparam int STM1_B2_ROW     = 4;

    localparam int POS_W = 15;
    localparam int ROW_W = 4;
    localparam int COL_W = 9;
    localparam int BIT_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } stm1_state_e;

endpackage

// File: rtl/stm1_pos_cnt.sv
// Cascaded frame position counters: bitn (0..7) -> col (0..COLS-1) -> row (0..ROWS-1),
// plus a linear pos (0..frame-1) kept alongside. No divider is used anywhere.
// Ports:
//  clk155   in   bit clock
//  rst      in   synchronous reset, active-high
//  clr      in   load zero into all counters on the next edge
//  inc      in   advance by one bit (ignored while clr)
//  pos/row/col/bitn          out  registered current position
//  nxt_pos/nxt_row/nxt_col/nxt_bitn  out  combinational next position, used by the
//                                         owner to register decodes aligned with pos
module stm1_pos_cnt
    import stm1_pkg::*;
#(
    parameter int COLS = STM1_COLS,
    parameter int ROWS = STM1_ROWS
) (
    input  logic             clk155,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [POS_W-1:0] pos,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic [BIT_W-1:0] bitn,
    output logic [POS_W-1:0] nxt_pos,
    output logic [ROW_W-1:0] nxt_row,
    output logic [COL_W-1:0] nxt_col,
    output logic [BIT_W-1:0] nxt_bitn
);

    localparam int FRAME = COLS * ROWS * 8;

    // Next-position computation: clear, cascaded increment with wrap, or hold.
    always_comb begin
        nxt_pos  = pos;
        nxt_row  = row;
        nxt_col  = col;
        nxt_bitn = bitn;
        if (clr) begin
            nxt_pos  = POS_W'(0);
            nxt_row  = ROW_W'(0);
            nxt_col  = COL_W'(0);
            nxt_bitn = BIT_W'(0);
        end else if (inc) begin
            nxt_pos = (pos == POS_W'(FRAME - 1)) ? POS_W'(0) : pos + POS_W'(1);
            if (bitn == BIT_W'(7)) begin
                nxt_bitn = BIT_W'(0);
                if (col == COL_W'(COLS - 1)) begin
                    nxt_col = COL_W'(0);
                    nxt_row = (row == ROW_W'(ROWS - 1)) ? ROW_W'(0) : row + ROW_W'(1);
                end else begin
                    nxt_col = col + COL_W'(1);
                end
            end else begin
                nxt_bitn = bitn + BIT_W'(1);
            end
        end else begin
            nxt_pos  = pos;
        end
    end

    // Position registers.
    always_ff @(posedge clk155) begin
        if (rst) begin
            pos  <= POS_W'(0);
            row  <= ROW_W'(0);
            col  <= COL_W'(0);
            bitn <= BIT_W'(0);
        end else begin
            pos  <= nxt_pos;
            row  <= nxt_row;
            col  <= nxt_col;
            bitn <= nxt_bitn;
        end
    end

endmodule

// File: rtl/stm1_soh_sched.sv
// Bit-serial STM-1 TX frame scheduler (1 bit per clk155 cycle, 19440 bits/frame).
// Owns the frame position, issues sof / RSOH window / B2 calc enable, captures the
// BIP-24 result on the rising edge of b2_vld and serialises it MSB-first into the
// three B2 bytes (row 4, cols 0..2).
// Optional feature macro: STM1_SCHED_FSYNC_EN (external frame sync / realign).
// Ports:
//  clk155, rst (sync, active-high), sched_en (run level), fsync_in (frame sync pulse),
//  b2_pdi[23:0]/b2_vld (BIP-24 result), sof, row[3:0], col[8:0], bitn[2:0], rsoh_win,
//  b2_calc_en, b2_ins, b2_sdo, b2_miss, realign. All outputs are registered.
module stm1_soh_sched
    import stm1_pkg::*;
#(
    parameter int COLS      = STM1_COLS,
    parameter int ROWS      = STM1_ROWS,
    parameter int SOH_COLS  = STM1_SOH_COLS,
    parameter int RSOH_ROWS = STM1_RSOH_ROWS,
    parameter int B2_ROW    = STM1_B2_ROW
) (
    input  logic             clk155,
    input  logic             rst,
    input  logic             sched_en,
    input  logic             fsync_in,
    input  logic [23:0]      b2_pdi,
    input  logic             b2_vld,
    output logic             sof,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic [BIT_W-1:0] bitn,
    output logic             rsoh_win,
    output logic             b2_calc_en,
    output logic             b2_ins,
    output logic             b2_sdo,
    output logic             b2_miss,
    output logic             realign
);

    localparam int FRAME = COLS * ROWS * 8;

    stm1_state_e      state;
    logic [POS_W-1:0] pos;
    logic [POS_W-1:0] nxt_pos;
    logic [ROW_W-1:0] nxt_row;
    logic [COL_W-1:0] nxt_col;
    logic [BIT_W-1:0] nxt_bitn;
    logic             fsync_hit;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             capture;
    logic             nxt_rsoh;
    logic             nxt_win;
    logic             win_first;
    logic             win_last;
    logic [23:0]      b2_src;
    logic             b2_vld_d;
    logic [23:0]      b2_hold;
    logic [23:0]      b2_shift;
    logic             b2_fresh;
    logic             cap_in_win;

`ifdef STM1_SCHED_FSYNC_EN
    assign fsync_hit = (state == RUN) & sched_en & fsync_in;
`else
    assign fsync_hit = 1'b0 & fsync_in;
`endif

    // In IDLE the counter is parked at zero so the first RUN cycle is pos 0.
    assign cnt_clr = (state == IDLE) | ~sched_en | fsync_hit;
    assign cnt_inc = (state == RUN);

    stm1_pos_cnt #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_pos_cnt (
        .clk155   (clk155),
        .rst      (rst),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .pos      (pos),
        .row      (row),
        .col      (col),
        .bitn     (bitn),
        .nxt_pos  (nxt_pos),
        .nxt_row  (nxt_row),
        .nxt_col  (nxt_col),
        .nxt_bitn (nxt_bitn)
    );

    // Decodes of the next position; registering them keeps outputs aligned with pos.
    assign nxt_rsoh  = (nxt_row < ROW_W'(RSOH_ROWS)) & (nxt_col < COL_W'(SOH_COLS));
    assign nxt_win   = sched_en & (nxt_row == ROW_W'(B2_ROW)) & (nxt_col < COL_W'(3));
    assign win_first = nxt_win & (nxt_col == COL_W'(0)) & (nxt_bitn == BIT_W'(0));
    assign win_last  = nxt_win & (nxt_col == COL_W'(2)) & (nxt_bitn == BIT_W'(7));
    assign capture   = b2_vld & ~b2_vld_d;
    // A capture coinciding with window start is forwarded straight into the window.
    assign b2_src    = capture ? b2_pdi : b2_hold;

    // Scheduler FSM, B2 capture/serialiser and registered output decodes.
    always_ff @(posedge clk155) begin
        if (rst) begin
            state      <= IDLE;
            sof        <= 1'b0;
            rsoh_win   <= 1'b0;
            b2_calc_en <= 1'b0;
            b2_ins     <= 1'b0;
            b2_sdo     <= 1'b0;
            b2_miss    <= 1'b0;
            realign    <= 1'b0;
            b2_vld_d   <= 1'b0;
            b2_hold    <= 24'd0;
            b2_shift   <= 24'd0;
            b2_fresh   <= 1'b0;
            cap_in_win <= 1'b0;
        end else begin
            case (state)
                IDLE:    state <= sched_en ? RUN : IDLE;
                RUN:     state <= sched_en ? RUN : IDLE;
                default: state <= IDLE;
            endcase

            b2_vld_d   <= b2_vld;
            sof        <= sched_en & (nxt_pos == POS_W'(0));
            rsoh_win   <= sched_en & nxt_rsoh;
            b2_calc_en <= sched_en & ~nxt_rsoh;
            b2_ins     <= nxt_win;
            realign    <= fsync_hit & (pos != POS_W'(FRAME - 1));

            if (capture) begin
                b2_hold <= b2_pdi;
            end else begin
                b2_hold <= b2_hold;
            end

            if (win_first) begin
                b2_shift   <= b2_src;
                b2_sdo     <= b2_src[23];
                b2_miss    <= ~(b2_fresh | capture);
                cap_in_win <= 1'b0;
            end else if (nxt_win) begin
                // Mid-window captures only update b2_hold; the word in flight is untouched.
                b2_shift   <= {b2_shift[22:0], 1'b0};
                b2_sdo     <= b2_shift[22];
                b2_miss    <= 1'b0;
                cap_in_win <= cap_in_win | capture;
            end else begin
                b2_sdo     <= 1'b0;
                b2_miss    <= 1'b0;
            end

            // The sent word is consumed at the last bit; a capture seen inside the
            // window (after its start) survives as fresh for the next frame.
            if (win_last) begin
                b2_fresh <= capture | cap_in_win;
            end else if (capture) begin
                b2_fresh <= 1'b1;
            end else begin
                b2_fresh <= b2_fresh;
            end
        end
    end

endmodule

// File: tb/tb_stm1_soh_sched.sv
// Directed self-checking bench for stm1_soh_sched.
// Frames: 1 = capture early (A5C3F0 sent), 2 = no capture (miss, A5C3F0 re-sent,
// fsync at the natural wrap), 3 = capture exactly at window start plus a second
// capture mid-window, 4 = that mid-window value sent next frame, cut by rst at pos 8650.
module tb_stm1_soh_sched;

    logic        clk155;
    logic        rst;
    logic        sched_en;
    logic        fsync_in;
    logic [23:0] b2_pdi;
    logic        b2_vld;
    logic        sof;
    logic [3:0]  row;
    logic [8:0]  col;
    logic [2:0]  bitn;
    logic        rsoh_win;
    logic        b2_calc_en;
    logic        b2_ins;
    logic        b2_sdo;
    logic        b2_miss;
    logic        realign;

    int n_checks = 0;
    int n_errors = 0;

    stm1_soh_sched dut (
        .clk155     (clk155),
        .rst        (rst),
        .sched_en   (sched_en),
        .fsync_in   (fsync_in),
        .b2_pdi     (b2_pdi),
        .b2_vld     (b2_vld),
        .sof        (sof),
        .row        (row),
        .col        (col),
        .bitn       (bitn),
        .rsoh_win   (rsoh_win),
        .b2_calc_en (b2_calc_en),
        .b2_ins     (b2_ins),
        .b2_sdo     (b2_sdo),
        .b2_miss    (b2_miss),
        .realign    (realign)
    );

    initial clk155 = 1'b0;
    always #5 clk155 = ~clk155;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {9'd0, sof, row, col, bitn, rsoh_win, b2_calc_en, b2_ins, b2_sdo, b2_miss, realign};
    endfunction

    // Runs p = 0..stop_at-1 (outputs sampled at each negedge show position p) and
    // drives inputs for the following edge. b2_vld is high for 8 cycles from each vld_at.
    task automatic run_frame(input string tag,
                             input int vld_at1, input logic [23:0] word1,
                             input int vld_at2, input logic [23:0] word2,
                             input int fsync_at, input int stop_at,
                             input logic [23:0] exp_word, input logic exp_miss);
        int m_pos = 0, m_sof = 0, m_rsoh = 0, m_calc = 0, m_ins = 0;
        int m_miss = 0, m_realign = 0;
        int c_rsoh = 0, c_calc = 0, c_ins = 0, c_miss = 0, nbits = 0;
        logic [23:0] got = 24'd0;
        logic [23:0] exp_w;
        exp_w = exp_word;
        for (int p = 0; p < stop_at; p++) begin
            int  e_row, e_col, e_bit;
            logic e_rsoh, e_ins;
            e_row  = p / 2160;
            e_col  = (p % 2160) / 8;
            e_bit  = p % 8;
            e_rsoh = (e_row < 3) && (e_col < 9);
            e_ins  = (p >= 8640) && (p <= 8663);
            if (row !== 4'(e_row) || col !== 9'(e_col) || bitn !== 3'(e_bit)) m_pos++;
            if (sof !== (p == 0)) m_sof++;
            if (rsoh_win !== e_rsoh) m_rsoh++;
            if (b2_calc_en !== !e_rsoh) m_calc++;
            if (b2_ins !== e_ins) m_ins++;
            if (b2_miss !== (exp_miss && p == 8640)) m_miss++;
            if (realign !== 1'b0) m_realign++;
            c_rsoh += int'(rsoh_win);
            c_calc += int'(b2_calc_en);
            c_ins  += int'(b2_ins);
            c_miss += int'(b2_miss);
            if (e_ins) begin
                got[23 - (p - 8640)] = b2_sdo;
                nbits++;
            end else if (b2_sdo !== 1'b0) begin
                m_ins++;
            end
            if (p >= vld_at1 && p < vld_at1 + 8) begin
                b2_vld = 1'b1;
                b2_pdi = word1;
            end else if (p >= vld_at2 && p < vld_at2 + 8) begin
                b2_vld = 1'b1;
                b2_pdi = word2;
            end else begin
                b2_vld = 1'b0;
            end
            fsync_in = (p == fsync_at);
            @(negedge clk155);
        end
        check_val({tag, "_pos"}, 32'(m_pos), 32'd0);
        check_val({tag, "_sof"}, 32'(m_sof), 32'd0);
        check_val({tag, "_rsoh"}, 32'(m_rsoh), 32'd0);
        check_val({tag, "_calc_en"}, 32'(m_calc), 32'd0);
        check_val({tag, "_ins"}, 32'(m_ins), 32'd0);
        check_val({tag, "_miss_pos"}, 32'(m_miss), 32'd0);
        check_val({tag, "_miss_cnt"}, 32'(c_miss), 32'(exp_miss));
        check_val({tag, "_realign"}, 32'(m_realign), 32'd0);
        check_val({tag, "_b2_word"}, 32'(got >> (24 - nbits)), 32'(exp_w >> (24 - nbits)));
        if (stop_at == 19440) begin
            check_val({tag, "_rsoh_cnt"}, 32'(c_rsoh), 32'd216);
            check_val({tag, "_calc_cnt"}, 32'(c_calc), 32'd19224);
            check_val({tag, "_ins_cnt"}, 32'(c_ins), 32'd24);
        end
    endtask

    initial begin
        rst      = 1'b1;
        sched_en = 1'b0;
        fsync_in = 1'b0;
        b2_pdi   = 24'd0;
        b2_vld   = 1'b0;
        repeat (3) @(negedge clk155);
        check_val("reset_outs", all_outs(), 32'd0);

        rst = 1'b0;
        repeat (2) @(negedge clk155);
        check_val("idle_outs", all_outs(), 32'd0);

        sched_en = 1'b1;
        @(negedge clk155);
        check_val("first_sof", {31'd0, sof}, 32'd1);
        check_val("first_rowcolbit", {16'd0, row, col, bitn}, 32'd0);

        run_frame("f1", 100, 24'hA5C3F0, -100, 24'd0, -1, 19440, 24'hA5C3F0, 1'b0);
        check_val("wrap_sof", {31'd0, sof}, 32'd1);
        check_val("wrap_rowcolbit", {16'd0, row, col, bitn}, 32'd0);
        run_frame("f2", -100, 24'd0, -100, 24'd0, 19439, 19440, 24'hA5C3F0, 1'b1);
        run_frame("f3", 8639, 24'h3C5A96, 8655, 24'h123456, -1, 19440, 24'h3C5A96, 1'b0);
        run_frame("f4", -100, 24'd0, -100, 24'd0, -1, 8650, 24'h123456, 1'b0);

        // Now at pos 8650, inside the B2 window.
        check_val("pre_rst_ins", {31'd0, b2_ins}, 32'd1);
        rst = 1'b1;
        @(negedge clk155);
        check_val("rst_mid_outs", all_outs(), 32'd0);
        rst = 1'b0;
        @(negedge clk155);
        check_val("restart_sof", {31'd0, sof}, 32'd1);
        check_val("restart_rowcolbit", {16'd0, row, col, bitn}, 32'd0);

`ifdef STM1_SCHED_FSYNC_EN
        repeat (5000) @(negedge clk155);
        check_val("pre_fsync_pos", {16'd0, row, col, bitn}, {16'd0, 4'd2, 9'd85, 3'd0});
        fsync_in = 1'b1;
        @(negedge clk155);
        fsync_in = 1'b0;
        check_val("fsync_sof", {31'd0, sof}, 32'd1);
        check_val("fsync_realign", {31'd0, realign}, 32'd1);
        check_val("fsync_rowcolbit", {16'd0, row, col, bitn}, 32'd0);
        @(negedge clk155);
        check_val("realign_pulse_end", {31'd0, realign}, 32'd0);
`endif

        repeat (3) @(negedge clk155);
        sched_en = 1'b0;
        @(negedge clk155);
        check_val("stop_outs", all_outs(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
